// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART receiver and its baud tick generator.
`timescale 1ns/1ps
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } uart_state_e;

  // Clamped to 1 so an over-fast baud request still yields a running tick.
  function automatic int unsigned calc_div(input int unsigned clk_freq,
                                           input int unsigned baud,
                                           input int unsigned oversample);
    int unsigned div;
    div = clk_freq / (baud * oversample);
    return (div == 32'd0) ? 32'd1 : div;
  endfunction

  function automatic int unsigned calc_mid(input int unsigned oversample);
    return oversample / 32'd2;
  endfunction

  function automatic bit data_bits_ok(input int unsigned n);
    return (n >= 32'd5) && (n <= 32'd16);
  endfunction

  function automatic bit stop_bits_ok(input int unsigned n);
    return (n == 32'd1) || (n == 32'd2);
  endfunction

  function automatic bit oversample_ok(input int unsigned n);
    return (n >= 32'd8) && ((n % 32'd2) == 32'd0);
  endfunction

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversampling baud tick: one-cycle pulse every DIV clocks, re-phased by i_restart.
`timescale 1ns/1ps
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_restart,
  output logic o_tick
);

  localparam int unsigned DIV = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
  localparam int unsigned CW  = (DIV > 32'd1) ? $clog2(DIV) : 32'd1;

  logic [CW-1:0] cnt_r;
  logic          tick_r;

  // Free-running divider; a restart zeroes the phase so ticks line up with the start edge.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      cnt_r  <= '0;
      tick_r <= 1'b0;
    end else if (i_restart) begin
      cnt_r  <= '0;
      tick_r <= 1'b0;
    end else if (cnt_r == CW'(DIV - 32'd1)) begin
      cnt_r  <= '0;
      tick_r <= 1'b1;
    end else begin
      cnt_r  <= cnt_r + CW'(1);
      tick_r <= 1'b0;
    end
  end

  assign o_tick = tick_r;

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver with majority-vote sampling and valid/ready output.
// Optional parity checking is enabled with the UART_RX_PARITY_EN macro.
`timescale 1ns/1ps
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DATA_BITS  = 10,
  parameter int unsigned STOP_BITS  = 1
`ifdef UART_RX_PARITY_EN
  ,
  parameter bit          PARITY_ODD = 1'b0
`endif
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  input  logic                 i_rx,
  input  logic                 i_ready,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_valid,
  output logic                 o_frame_err,
  output logic                 o_overrun
`ifdef UART_RX_PARITY_EN
  ,
  output logic                 o_parity_err
`endif
);

  localparam int unsigned MID = calc_mid(OVERSAMPLE);
  localparam int unsigned TW  = $clog2(OVERSAMPLE);

  if (!data_bits_ok(DATA_BITS) || !stop_bits_ok(STOP_BITS) || !oversample_ok(OVERSAMPLE)) begin : g_bad_cfg
    $error("uart_rx_param: illegal DATA_BITS, STOP_BITS or OVERSAMPLE");
  end

  uart_state_e          state_r, state_s;
  logic                 rx_meta_r, rx_sync_r, rx_prev_r;
  logic [1:0]           settle_r;
  logic                 armed_r;
  logic                 tick_s, restart_s;
  logic [TW-1:0]        tick_cnt_r;
  logic [1:0]           smp_r;
  logic [4:0]           bit_cnt_r;
  logic [DATA_BITS-1:0] shift_r, data_r;
  logic                 valid_r, frame_err_r, overrun_r;
  logic                 vote_now_s, vote_s, accept_s;
  logic                 load_s, fe_s, ov_s, shift_en_s, bit_clr_s, bit_inc_s;
`ifdef UART_RX_PARITY_EN
  logic                 par_bad_r, parity_err_r, pe_s;
`endif

  uart_baud_tick #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD      (BAUD),
    .OVERSAMPLE(OVERSAMPLE)
  ) u_baud_tick (
    .i_clk    (i_clk),
    .i_reset_n(i_reset_n),
    .i_restart(restart_s),
    .o_tick   (tick_s)
  );

  // Input synchronizer; armed_r only sets once the flushed line has been seen high.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
      rx_prev_r <= 1'b1;
      settle_r  <= 2'd0;
      armed_r   <= 1'b0;
    end else begin
      rx_meta_r <= i_rx;
      rx_sync_r <= rx_meta_r;
      rx_prev_r <= rx_sync_r;
      settle_r  <= (settle_r == 2'd3) ? 2'd3 : settle_r + 2'd1;
      armed_r   <= armed_r | ((settle_r == 2'd3) & rx_sync_r);
    end
  end

  assign vote_now_s = tick_s && (tick_cnt_r == TW'(MID));
  assign vote_s     = maj3(smp_r[0], smp_r[1], rx_sync_r);
  assign accept_s   = !valid_r || i_ready;

  // Next-state and per-cycle control; all decisions are taken on the vote tick.
  always_comb begin
    state_s    = state_r;
    restart_s  = 1'b0;
    load_s     = 1'b0;
    fe_s       = 1'b0;
    ov_s       = 1'b0;
    shift_en_s = 1'b0;
    bit_clr_s  = 1'b0;
    bit_inc_s  = 1'b0;
`ifdef UART_RX_PARITY_EN
    pe_s       = 1'b0;
`endif
    case (state_r)
      ST_IDLE: begin
        if (armed_r && rx_prev_r && !rx_sync_r) begin
          state_s   = ST_START;
          restart_s = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_START: begin
        if (vote_now_s) begin
          state_s   = vote_s ? ST_IDLE : ST_DATA;
          bit_clr_s = 1'b1;
        end else begin
          state_s = ST_START;
        end
      end
      ST_DATA: begin
        if (vote_now_s) begin
          shift_en_s = 1'b1;
          if (bit_cnt_r == 5'(DATA_BITS - 32'd1)) begin
            bit_clr_s = 1'b1;
`ifdef UART_RX_PARITY_EN
            state_s = ST_PARITY;
`else
            state_s = ST_STOP;
`endif
          end else begin
            bit_inc_s = 1'b1;
          end
        end else begin
          state_s = ST_DATA;
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        state_s = vote_now_s ? ST_STOP : ST_PARITY;
      end
`endif
      ST_STOP: begin
        if (vote_now_s) begin
          if (!vote_s) begin
            state_s = ST_BREAK;
            fe_s    = 1'b1;
          end else if (bit_cnt_r == 5'(STOP_BITS - 32'd1)) begin
            state_s = ST_IDLE;
`ifdef UART_RX_PARITY_EN
            pe_s   = par_bad_r;
            load_s = !par_bad_r && accept_s;
            ov_s   = !par_bad_r && !accept_s;
`else
            load_s = accept_s;
            ov_s   = !accept_s;
`endif
          end else begin
            bit_inc_s = 1'b1;
          end
        end else begin
          state_s = ST_STOP;
        end
      end
      ST_BREAK: begin
        state_s = rx_sync_r ? ST_IDLE : ST_BREAK;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Frame-tracking state: FSM, tick/bit position, vote samples and shift register.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_r    <= ST_IDLE;
      tick_cnt_r <= '0;
      smp_r      <= 2'b11;
      bit_cnt_r  <= 5'd0;
      shift_r    <= '0;
    end else begin
      state_r <= state_s;
      if (restart_s || (state_r == ST_IDLE)) begin
        tick_cnt_r <= '0;
      end else if (tick_s) begin
        tick_cnt_r <= (tick_cnt_r == TW'(OVERSAMPLE - 32'd1)) ? '0 : tick_cnt_r + TW'(1);
      end
      if (tick_s && (tick_cnt_r == TW'(MID - 32'd2))) begin
        smp_r[0] <= rx_sync_r;
      end
      if (tick_s && (tick_cnt_r == TW'(MID - 32'd1))) begin
        smp_r[1] <= rx_sync_r;
      end
      if (bit_clr_s) begin
        bit_cnt_r <= 5'd0;
      end else if (bit_inc_s) begin
        bit_cnt_r <= bit_cnt_r + 5'd1;
      end
      if (shift_en_s) begin
        shift_r <= {vote_s, shift_r[DATA_BITS-1:1]};
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  // Parity verdict captured at the parity vote, consumed at the final stop bit.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      par_bad_r    <= 1'b0;
      parity_err_r <= 1'b0;
    end else begin
      parity_err_r <= pe_s;
      if (restart_s) begin
        par_bad_r <= 1'b0;
      end else if ((state_r == ST_PARITY) && vote_now_s) begin
        par_bad_r <= (^shift_r) ^ vote_s ^ PARITY_ODD;
      end
    end
  end

  assign o_parity_err = parity_err_r;
`endif

  // Holding register: a load wins over an accept in the same cycle.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      data_r      <= '0;
      valid_r     <= 1'b0;
      frame_err_r <= 1'b0;
      overrun_r   <= 1'b0;
    end else begin
      frame_err_r <= fe_s;
      overrun_r   <= ov_s;
      if (load_s) begin
        data_r  <= shift_r;
        valid_r <= 1'b1;
      end else if (i_ready) begin
        valid_r <= 1'b0;
      end
    end
  end

  assign o_data      = data_r;
  assign o_valid     = valid_r;
  assign o_frame_err = frame_err_r;
  assign o_overrun   = overrun_r;

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed, table-driven bench for uart_rx_param at a fast baud rate (DIV = 4, 1280 ns/bit).
`timescale 1ns/1ps
module tb_uart_rx_param;
  import uart_pkg::*;

  localparam int BIT_NS = 1280;

  logic       tb_clk = 1'b0;
  logic       i_reset_n, i_rx, i_ready;
  logic [9:0] o_data;
  logic       o_valid, o_frame_err, o_overrun;
  int         n_pass = 0, n_total = 0;
  int         fe_cnt = 0, ov_cnt = 0;
`ifdef UART_RX_PARITY_EN
  localparam logic PAR_ODD_TB = 1'b1;
  logic       o_parity_err;
  logic       par_flip = 1'b0;
  int         pe_cnt = 0;
`endif

  always #10 tb_clk = ~tb_clk;

  uart_rx_param #(
    .CLK_FREQ  (50_000_000),
    .BAUD      (781_250),
    .OVERSAMPLE(16),
    .DATA_BITS (10),
    .STOP_BITS (1)
`ifdef UART_RX_PARITY_EN
    , .PARITY_ODD(1'b1)
`endif
  ) dut (
    .i_clk      (tb_clk),
    .i_reset_n  (i_reset_n),
    .i_rx       (i_rx),
    .i_ready    (i_ready),
    .o_data     (o_data),
    .o_valid    (o_valid),
    .o_frame_err(o_frame_err),
    .o_overrun  (o_overrun)
`ifdef UART_RX_PARITY_EN
    , .o_parity_err(o_parity_err)
`endif
  );

  // Pulse counters; a one-cycle pulse is seen at exactly one falling edge.
  always @(negedge tb_clk) begin
    if (o_frame_err) fe_cnt <= fe_cnt + 1;
    if (o_overrun)   ov_cnt <= ov_cnt + 1;
`ifdef UART_RX_PARITY_EN
    if (o_parity_err) pe_cnt <= pe_cnt + 1;
`endif
  end

  typedef struct {
    logic [9:0] data;
    logic       stop;
    int         gap_bits;
    logic       accept;
    logic       exp_valid;
    logic       chk_data;
    logic [9:0] exp_data;
    int         exp_fe;
    int         exp_ov;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic send_frame(input logic [9:0] d, input logic stop_v);
    i_rx = 1'b0;
    #(BIT_NS);
    for (int i = 0; i < 10; i++) begin
      i_rx = d[i];
      #(BIT_NS);
    end
`ifdef UART_RX_PARITY_EN
    i_rx = (^d) ^ PAR_ODD_TB ^ par_flip;
    #(BIT_NS);
`endif
    i_rx = stop_v;
    #(BIT_NS);
    i_rx = 1'b1;
  endtask

  task automatic accept_word(input string name);
    @(negedge tb_clk);
    i_ready = 1'b1;
    @(negedge tb_clk);
    i_ready = 1'b0;
    check(name, 32'(o_valid), 32'd0);
  endtask

  initial begin
    int fe0, ov0;

    vecs[0] = '{10'h355, 1'b1, 1, 1'b1, 1'b1, 1'b1, 10'h355, 0, 0};
    vecs[1] = '{10'h2A5, 1'b0, 1, 1'b0, 1'b0, 1'b0, 10'h000, 1, 0};
    vecs[2] = '{10'h0FF, 1'b1, 2, 1'b1, 1'b1, 1'b1, 10'h0FF, 0, 0};
    vecs[3] = '{10'h155, 1'b1, 1, 1'b0, 1'b1, 1'b1, 10'h155, 0, 0};
    vecs[4] = '{10'h2AA, 1'b1, 0, 1'b1, 1'b1, 1'b1, 10'h155, 0, 1};
    vecs[5] = '{10'h000, 1'b1, 1, 1'b1, 1'b1, 1'b1, 10'h000, 0, 0};
    vecs[6] = '{10'h3FF, 1'b1, 1, 1'b0, 1'b1, 1'b1, 10'h3FF, 0, 0};

    // Reset
    i_reset_n = 1'b0;
    i_rx      = 1'b1;
    i_ready   = 1'b0;
    repeat (5) @(negedge tb_clk);
    check("rst o_valid", 32'(o_valid), 32'd0);
    check("rst o_data", 32'(o_data), 32'd0);
    check("rst o_frame_err", 32'(o_frame_err), 32'd0);
    check("rst o_overrun", 32'(o_overrun), 32'd0);
    check("rst state", 32'(dut.state_r), 32'(ST_IDLE));
    i_reset_n = 1'b1;
    repeat (10) @(negedge tb_clk);

    // Glitch shorter than the vote window
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    i_rx = 1'b0;
    #400;
    i_rx = 1'b1;
    #(BIT_NS);
    check("glitch o_valid", 32'(o_valid), 32'd0);
    check("glitch frame_err", 32'(fe_cnt - fe0), 32'd0);
    check("glitch overrun", 32'(ov_cnt - ov0), 32'd0);
    check("glitch state", 32'(dut.state_r), 32'(ST_IDLE));

    // Table of frames
    for (int i = 0; i < 7; i++) begin
      @(negedge tb_clk);
      #(vecs[i].gap_bits * BIT_NS);
      fe0 = fe_cnt;
      ov0 = ov_cnt;
      send_frame(vecs[i].data, vecs[i].stop);
      repeat (5) @(negedge tb_clk);
      check($sformatf("row%0d o_valid", i), 32'(o_valid), 32'(vecs[i].exp_valid));
      if (vecs[i].chk_data) check($sformatf("row%0d o_data", i), 32'(o_data), 32'(vecs[i].exp_data));
      check($sformatf("row%0d frame_err pulses", i), 32'(fe_cnt - fe0), 32'(vecs[i].exp_fe));
      check($sformatf("row%0d overrun pulses", i), 32'(ov_cnt - ov0), 32'(vecs[i].exp_ov));
      if (vecs[i].exp_valid) begin
        repeat (100) @(negedge tb_clk);
        check($sformatf("row%0d held o_valid", i), 32'(o_valid), 32'd1);
        check($sformatf("row%0d held o_data", i), 32'(o_data), 32'(vecs[i].exp_data));
      end
      if (vecs[i].accept) accept_word($sformatf("row%0d accept", i));
    end

    // Reset in the middle of a data bit, line low at release
    @(negedge tb_clk);
    i_rx = 1'b0;
    #(BIT_NS);
    for (int b = 0; b < 4; b++) begin
      i_rx = b[0] ? 1'b1 : 1'b0;
      #(BIT_NS);
    end
    i_rx = 1'b0;
    #(BIT_NS / 2);
    i_reset_n = 1'b0;
    repeat (5) @(negedge tb_clk);
    check("midrst o_valid", 32'(o_valid), 32'd0);
    check("midrst o_data", 32'(o_data), 32'd0);
    check("midrst state", 32'(dut.state_r), 32'(ST_IDLE));
    i_reset_n = 1'b1;
    #(2 * BIT_NS);
    check("midrst low line state", 32'(dut.state_r), 32'(ST_IDLE));
    check("midrst low line o_valid", 32'(o_valid), 32'd0);
    i_rx = 1'b1;
    #(2 * BIT_NS);
    @(negedge tb_clk);
    send_frame(10'h1E7, 1'b1);
    repeat (5) @(negedge tb_clk);
    check("post-rst o_valid", 32'(o_valid), 32'd1);
    check("post-rst o_data", 32'(o_data), 32'h1E7);
    accept_word("post-rst accept");

`ifdef UART_RX_PARITY_EN
    // Wrong odd-parity bit drops the word, then a good frame is received
    #(BIT_NS);
    @(negedge tb_clk);
    begin
      int pe0;
      pe0 = pe_cnt;
      fe0 = fe_cnt;
      par_flip = 1'b1;
      send_frame(10'h355, 1'b1);
      par_flip = 1'b0;
      repeat (5) @(negedge tb_clk);
      check("parity err pulses", 32'(pe_cnt - pe0), 32'd1);
      check("parity o_valid", 32'(o_valid), 32'd0);
      check("parity frame_err", 32'(fe_cnt - fe0), 32'd0);
      #(BIT_NS);
      @(negedge tb_clk);
      send_frame(10'h0F0, 1'b1);
      repeat (5) @(negedge tb_clk);
      check("parity ok o_valid", 32'(o_valid), 32'd1);
      check("parity ok o_data", 32'(o_data), 32'h0F0);
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/uart_rx_param.md
# uart_rx_param

Parametrised UART receiver, the next generation of the fixed 10-bit `top_uart` receive path. It carries its own oversampling baud-tick generator and a two-flop input synchronizer, and receives frames of configurable width with majority-vote bit sampling. It detects framing errors and overruns, and presents each received word through a valid/ready holding register to the downstream opcode/operand decoder.

## Interface
- `CLK_FREQ`, 50_000_000, system clock frequency in Hz.
- `BAUD`, 9600, line bit rate.
- `OVERSAMPLE`, 16, ticks per bit; must be an even number ≥ 8.
- `DATA_BITS`, 10, payload width; legal range 5..16.
- `STOP_BITS`, 1, number of stop bits; 1 or 2.
- `PARITY_ODD`, 0, selects parity sense: 0 = even, 1 = odd. Used only with `UART_RX_PARITY_EN`.
- `i_clk`  in  1  system clock.
- `i_reset_n`  in  1  asynchronous, active-low reset.
- `i_rx`  in  1  serial line, asynchronous; idle level is 1.
- `i_ready`  in  1  consumer accepts `o_data` this cycle.
- `o_data`  out  DATA_BITS  received word, LSB first on the line.
- `o_valid`  out  1  `o_data` holds an unconsumed word.
- `o_frame_err`  out  1  one-cycle pulse: a stop bit was sampled as 0.
- `o_overrun`  out  1  one-cycle pulse: a frame was dropped because the holding register was full.
- `o_parity_err`  out  1  one-cycle pulse: parity mismatch. Present only with `UART_RX_PARITY_EN`.

## Operation
- **Reset.** All outputs reset to 0, the FSM goes to IDLE and all counters clear. The synchronizer flops reset to 1 (idle line).
- **Baud tick.** `DIV = CLK_FREQ/(BAUD*OVERSAMPLE)`, integer-truncated (325 at the defaults). A one-cycle tick is produced every `DIV` clocks. The counter free-runs and restarts from 0 when a start edge is detected.
- **Sampling.** Each bit value is the majority vote of the synchronized line at ticks `MID-1`, `MID` and `MID+1`, where `MID = OVERSAMPLE/2`.
- **State machine.**
  - IDLE → START on the synchronized line going 1→0.
  - START → IDLE if the voted value is 1 (glitch reject).
  - START → DATA if the voted value is 0.
  - DATA: shift in `DATA_BITS` bits LSB first, one per OVERSAMPLE ticks.
  - DATA → PARITY (macro on) or STOP.
  - STOP: checks each stop bit.
  - STOP → IDLE when all stop bits are 1.
  - STOP → BREAK on any 0 stop bit.
  - BREAK → IDLE once the synchronized line reads 1.
- **Frame completion.** On the last stop-bit vote:
  - If `o_valid`=0, or `i_ready`=1 in the same cycle, load the holding register.
  - Otherwise pulse `o_overrun`, discard the new word and keep the old one.
- **Framing or parity error.** `o_valid` is not raised. The word is discarded and the error pulse fires instead.
- **Handshake.** `o_valid` and `o_data` stay stable until `i_ready`=1. An accept and a load in the same cycle leave `o_valid`=1 with the new data.
- **Reset mid-frame.** The partial frame is lost and the block returns to IDLE. If the line is low when reset releases, it does not start a frame until it first sees 1.

## Timing
- Synchronizer delay: 2 cycles.
- `o_valid` rises 1 cycle after the tick at which the final stop bit is voted. That is about `(1 + DATA_BITS [+1] + STOP_BITS - 0.5)` bit times after the start edge, +3 cycles.
- Error and overrun pulses are exactly 1 cycle wide and aligned with the cycle in which `o_valid` would otherwise rise.
- No combinational path from `i_rx` to any output. `i_ready` → `o_valid` has one register stage.

## Configuration
- Macro: `UART_RX_PARITY_EN`.
- **Defined:** a parity bit follows the data bits, with even or odd sense set by `PARITY_ODD`. A mismatch pulses `o_parity_err` and drops the word, and the FSM proceeds to STOP normally.
- **Undefined:** there is no PARITY state, no `o_parity_err` port, and the frame is start + DATA_BITS + stop.

## Structure
- Package `uart_pkg` holds:
  - the FSM state encoding (IDLE, START, DATA, PARITY, STOP, BREAK);
  - the `MID` and `DIV` helper functions;
  - the legal-range checks for `DATA_BITS` and `STOP_BITS`.
- One sub-module, `uart_baud_tick` (parameters `CLK_FREQ`, `BAUD`, `OVERSAMPLE`; inputs `i_clk`, `i_reset_n`, restart; output tick). It is shared with the future transmitter.

## Test plan
- **Reset.** Defaults, `i_reset_n`=0 for 5 cycles → all outputs 0 and FSM in IDLE.
- **Normal frame.** Send start, bits of `10'h355` LSB first at 104160 ns/bit, then stop, with `i_ready`=0.
  - `o_valid`=1 and `o_data`=`10'h355`, held stable until `i_ready`=1.
  - `o_valid` drops the cycle after accept.
- **Glitch.** Drive `i_rx` low for 2 µs, then back to 1 → no `o_valid`, no error, and the FSM is back in IDLE before the next tick window.
- **Framing error, then recovery.**
  - Send a frame with stop bit = 0 → single-cycle `o_frame_err` and no `o_valid`.
  - Hold the line at 1, then send `10'h0FF` → `o_data`=`10'h0FF`.
- **Overrun.** Send two back-to-back frames `10'h155` and `10'h2AA` with `i_ready`=0.
  - `o_overrun` pulses at the end of the second frame.
  - `o_data` remains `10'h155`.
- **Parity and reset mid-frame.**
  - With `UART_RX_PARITY_EN`, `PARITY_ODD`=1 and a wrong parity bit → `o_parity_err` pulse and no `o_valid`.
  - Assert `i_reset_n` mid-data-bit → outputs 0, and the next full frame is received correctly.
